seg_hex_decoder: RTL and testbench
==================================

# seg_hex_decoder

- Reverse-direction companion to the hex-to-7-segment encoder: watches a multiplexed, active-low 7-segment bus plus its one-hot digit select, and recovers the 4-bit hex value shown on each digit.
- Used for display self-test and readback in the car-alarm design: it confirms that what the panel is driven with matches what the controller intended.
- A pattern must be held stable for a programmable number of cycles before it is accepted, which filters scan transitions and glitches.
- Per-digit values, valid flags, error flags and an update strobe are all registered outputs.

## Interface

- NUM_DIGITS, 4, number of multiplexed digits; legal range 1..8.
- STABLE_CYCLES, 4, consecutive identical samples required before a pattern is accepted; legal range 1..255.

- iCLK  in  1  system clock; all logic on rising edge.
- iRST  in  1  reset; asynchronous, active-high.
- iHEX_D  in  7  segment bus, active-low; bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g.
- iDIG_SEL  in  NUM_DIGITS  digit enable, active-high, expected one-hot; bit i means the bus currently drives digit i.
- iCLR  in  1  synchronous clear of all oVALID and oERR bits.
- oDIG  out  4*NUM_DIGITS  decoded value per digit; digit i occupies bits [4i+3:4i].
- oVALID  out  NUM_DIGITS  digit i holds an accepted, recognised pattern.
- oERR  out  NUM_DIGITS  last accepted pattern on digit i was unrecognised.
- oUPDATE  out  1  one-cycle strobe following every acceptance.

## Operation

- **Input sampling**
  - iHEX_D and iDIG_SEL are registered every cycle into s_pat and s_sel.
  - The previous sample is kept for comparison.
- **Decode table** (active-low pattern -> value)
  - 1000000->0, 1111001->1, 0100100->2, 0110000->3
  - 0011001->4, 0010010->5, 0000010->6, 1111000->7
  - 0000000->8, 0011000->9, 0001000->A, 0000011->B
  - 1000110->C, 0100001->D, 0000110->E, 0001110->F
  - Any other pattern (including all-off 1111111) is unrecognised.
- **State machine** (the counter cnt saturates at STABLE_CYCLES)
  - IDLE: s_sel is not one-hot (zero bits or more than one bit set).
    - cnt=0.
    - Go to TRACK, with cnt=1, on the first one-hot sample.
  - TRACK: a one-hot sample equal to the previous sample increments cnt.
    - A differing one-hot sample restarts the count at cnt=1 and stays in TRACK.
    - A non-one-hot sample goes to IDLE.
    - When cnt reaches STABLE_CYCLES, accept and go to LOCKED.
  - LOCKED: no further accepts while the sample is unchanged.
    - A differing one-hot sample goes to TRACK with cnt=1.
    - A non-one-hot sample goes to IDLE.
- **Accept** (selected digit i only)
  - Recognised pattern: oDIG[i]=decoded value, oVALID[i]=1, oERR[i]=0.
  - Unrecognised pattern: oDIG[i] keeps its old value, oVALID[i]=0, oERR[i]=1.
  - Other digits are untouched.
  - oUPDATE=1 for exactly one cycle, even when the value is unchanged.
- **Clear**
  - iCLR zeroes all oVALID and oERR bits.
  - oDIG is retained.
  - If iCLR and an accept coincide, the accept wins for digit i; all other digits are cleared.
- **Width rule**: cnt is clog2(STABLE_CYCLES+1) bits wide, so it never wraps.

## Timing

- **Reset**: iRST forces the following, asynchronously, regardless of the clock:
  - oDIG=0, oVALID=0, oERR=0, oUPDATE=0.
  - cnt=0, state=IDLE, sample registers=0.
- **Release**: the first evaluation happens at the first rising edge after iRST deasserts.
- **Latency**: inputs first sampled stable at edge E0 are accepted at edge E(STABLE_CYCLES). Outputs change at that edge, and oUPDATE is high in the following cycle.
  - With STABLE_CYCLES=1, acceptance happens at E1.
- **Glitch filtering**: a change of even one cycle during TRACK restarts the count. A pattern held for fewer than STABLE_CYCLES samples is never accepted.
- **Digit select changes**: a change of iDIG_SEL with iHEX_D unchanged counts as a new sample and restarts the count.
- **Reset mid-count**: iRST asserted during TRACK discards the pending sample; nothing is accepted.
- **Outputs**: no combinational path from any input to any output.

## Test plan

- **Reset**: assert iRST mid-TRACK.
  - All outputs 0 immediately, without waiting for a clock edge.
  - After release, the held pattern is accepted only after a full STABLE_CYCLES.
- **Full sweep**: STABLE_CYCLES=4. Drive iDIG_SEL=0001 and each of the 16 table patterns, each held 6 cycles.
  - oDIG[3:0] tracks 0..F.
  - oVALID[0]=1.
  - oUPDATE pulses once per pattern, 4 edges after the first stable sample.
- **Glitch**: hold 0100100 on digit 2 for 3 cycles, then 0110000 for 4 cycles.
  - Only value 3 is accepted; oDIG[11:8]=3.
  - Exactly one oUPDATE.
- **Unrecognised pattern**: digit 1 holds 2.
  - Drive 1111111 for 4 cycles: oERR[1]=1, oVALID[1]=0, oDIG[7:4] stays 2.
  - Then drive 1111001: oERR[1]=0, oVALID[1]=1, oDIG[7:4]=1.
- **Invalid select**: drive iDIG_SEL=0000, then 0110, each with valid patterns for 10 cycles.
  - No oUPDATE; all outputs unchanged.
- **Clear collision**: iCLR asserted on the accept edge for digit 3, with digits 0-2 valid.
  - oVALID=1000.
  - oDIG of digits 0-2 retained.
  - oUPDATE=1.

Source files
------------

// File: rtl/seg_hex_decoder.sv
// rtl/seg_hex_decoder.sv - recovers per-digit hex values from a multiplexed active-low 7-segment bus
module seg_hex_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    iCLK,
    input  logic                    iRST,
    input  logic [6:0]              iHEX_D,
    input  logic [NUM_DIGITS-1:0]   iDIG_SEL,
    input  logic                    iCLR,
    output logic [4*NUM_DIGITS-1:0] oDIG,
    output logic [NUM_DIGITS-1:0]   oVALID,
    output logic [NUM_DIGITS-1:0]   oERR,
    output logic                    oUPDATE
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [6:0]                s_pat_q, p_pat_q;
    logic [NUM_DIGITS-1:0]     s_sel_q, p_sel_q;
    logic [4*NUM_DIGITS-1:0]   dig_q;
    logic [NUM_DIGITS-1:0]     valid_q, err_q;
    logic                      update_q;

    logic                      sel_onehot;
    logic                      same_sample;
    logic                      accept;
    logic                      dec_ok;
    logic [3:0]                dec_val;

    always_comb begin
        dec_ok  = 1'b1;
        dec_val = 4'h0;
        case (s_pat_q)
            7'b1000000: dec_val = 4'h0;
            7'b1111001: dec_val = 4'h1;
            7'b0100100: dec_val = 4'h2;
            7'b0110000: dec_val = 4'h3;
            7'b0011001: dec_val = 4'h4;
            7'b0010010: dec_val = 4'h5;
            7'b0000010: dec_val = 4'h6;
            7'b1111000: dec_val = 4'h7;
            7'b0000000: dec_val = 4'h8;
            7'b0011000: dec_val = 4'h9;
            7'b0001000: dec_val = 4'hA;
            7'b0000011: dec_val = 4'hB;
            7'b1000110: dec_val = 4'hC;
            7'b0100001: dec_val = 4'hD;
            7'b0000110: dec_val = 4'hE;
            7'b0001110: dec_val = 4'hF;
            default:    dec_ok  = 1'b0;
        endcase
    end

    // The FSM judges the registered sample against the one before it.
    always_comb begin
        sel_onehot  = (s_sel_q != '0) && ((s_sel_q & (s_sel_q - 1'b1)) == '0);
        same_sample = (s_pat_q == p_pat_q) && (s_sel_q == p_sel_q);
        state_d     = state_q;
        cnt_d       = cnt_q;
        accept      = 1'b0;
        if (!sel_onehot) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = TRACK;
                    cnt_d   = CW'(1);
                end
                TRACK: begin
                    if (!same_sample)
                        cnt_d = CW'(1);
                    else if (cnt_q < CW'(STABLE_CYCLES))
                        cnt_d = cnt_q + 1'b1;
                end
                default: begin
                    if (!same_sample) begin
                        state_d = TRACK;
                        cnt_d   = CW'(1);
                    end
                end
            endcase
            if (state_d == TRACK && cnt_d == CW'(STABLE_CYCLES)) begin
                accept  = 1'b1;
                state_d = LOCKED;
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            s_pat_q  <= '0;
            p_pat_q  <= '0;
            s_sel_q  <= '0;
            p_sel_q  <= '0;
            dig_q    <= '0;
            valid_q  <= '0;
            err_q    <= '0;
            update_q <= 1'b0;
        end else begin
            s_pat_q  <= iHEX_D;
            s_sel_q  <= iDIG_SEL;
            p_pat_q  <= s_pat_q;
            p_sel_q  <= s_sel_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            update_q <= accept;
            // An accept on the selected digit takes priority over a clear.
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (accept && s_sel_q[i]) begin
                    if (dec_ok) begin
                        dig_q[4*i +: 4] <= dec_val;
                        valid_q[i]      <= 1'b1;
                        err_q[i]        <= 1'b0;
                    end else begin
                        valid_q[i]      <= 1'b0;
                        err_q[i]        <= 1'b1;
                    end
                end else if (iCLR) begin
                    valid_q[i] <= 1'b0;
                    err_q[i]   <= 1'b0;
                end
            end
        end
    end

    assign oDIG    = dig_q;
    assign oVALID  = valid_q;
    assign oERR    = err_q;
    assign oUPDATE = update_q;

endmodule

// File: tb/tb_seg_hex_decoder.sv
// tb/tb_seg_hex_decoder.sv - directed and randomized bench for seg_hex_decoder
module tb_seg_hex_decoder;

    localparam int ND = 4;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [6:0]    hex;
    logic [ND-1:0] sel;
    logic          clr;
    logic [4*ND-1:0] dig;
    logic [ND-1:0] valid;
    logic [ND-1:0] err;
    logic          upd;

    seg_hex_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .iCLK(clk), .iRST(rst), .iHEX_D(hex), .iDIG_SEL(sel), .iCLR(clr),
        .oDIG(dig), .oVALID(valid), .oERR(err), .oUPDATE(upd)
    );

    always #5 clk = ~clk;

    logic [6:0]    tbl [16];
    int            n_cmp = 0;
    int            n_bad = 0;

    // Reference model: run length of identical one-hot input samples;
    // a run reaching SC exactly schedules an accept for the following edge.
    logic [4*ND-1:0] m_dig;
    logic [ND-1:0] m_val, m_err;
    logic          m_upd;
    int            run;
    logic [6:0]    last_pat, pend_pat;
    logic [ND-1:0] last_sel, pend_sel;
    logic          pend;
    int            upd_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_decode(input logic [6:0] p, output logic ok, output logic [3:0] v);
        ok = 1'b0;
        v  = 4'h0;
        for (int k = 0; k < 16; k++)
            if (tbl[k] == p) begin
                ok = 1'b1;
                v  = 4'(k);
            end
    endfunction

    task automatic model_reset();
        m_dig = '0; m_val = '0; m_err = '0; m_upd = 1'b0;
        run = 0; last_pat = '0; last_sel = '0; pend = 1'b0;
        pend_pat = '0; pend_sel = '0;
    endtask

    task automatic step(input logic [6:0] p, input logic [ND-1:0] s, input logic c, input string tag);
        logic ok;
        logic [3:0] v;
        hex = p; sel = s; clr = c;
        @(posedge clk);
        #1;
        m_upd = pend;
        if (c) begin
            m_val = '0;
            m_err = '0;
        end
        if (pend) begin
            ref_decode(pend_pat, ok, v);
            for (int d = 0; d < ND; d++)
                if (pend_sel[d]) begin
                    if (ok) m_dig[4*d +: 4] = v;
                    m_val[d] = ok;
                    m_err[d] = !ok;
                end
        end
        if ($countones(s) == 1 && p == last_pat && s == last_sel && run > 0)
            run++;
        else
            run = ($countones(s) == 1) ? 1 : 0;
        last_pat = p; last_sel = s;
        pend = (run == SC);
        pend_pat = p; pend_sel = s;
        upd_seen += int'(upd);
        chk({tag, "_dig"}, 32'(dig), 32'(m_dig));
        chk({tag, "_valid"}, 32'(valid), 32'(m_val));
        chk({tag, "_err"}, 32'(err), 32'(m_err));
        chk({tag, "_upd"}, 32'(upd), 32'(m_upd));
    endtask

    initial begin
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        rst = 1'b1; hex = '0; sel = '0; clr = 1'b0;
        model_reset();
        upd_seen = 0;
        #12;
        chk("reset_dig", 32'(dig), 0);
        chk("reset_valid", 32'(valid), 0);
        chk("reset_err", 32'(err), 0);
        chk("reset_upd", 32'(upd), 0);
        rst = 1'b0;

        // Full sweep on digit 0
        for (int v = 0; v < 16; v++) begin
            upd_seen = 0;
            for (int j = 0; j < 6; j++) step(tbl[v], 4'b0001, 1'b0, "sweep");
            chk("sweep_val", 32'(dig[3:0]), 32'(v));
            chk("sweep_vbit", 32'(valid[0]), 1);
            chk("sweep_updcnt", 32'(upd_seen), 1);
        end

        // Glitch: short-held 2 followed by 3 on digit 2
        upd_seen = 0;
        for (int j = 0; j < 3; j++) step(tbl[2], 4'b0100, 1'b0, "glitch");
        for (int j = 0; j < 4; j++) step(tbl[3], 4'b0100, 1'b0, "glitch");
        for (int j = 0; j < 2; j++) step(tbl[3], 4'b0000, 1'b0, "glitch");
        chk("glitch_dig2", 32'(dig[11:8]), 3);
        chk("glitch_updcnt", 32'(upd_seen), 1);

        // Unrecognised pattern on digit 1
        for (int j = 0; j < 5; j++) step(tbl[2], 4'b0010, 1'b0, "unrec_pre");
        for (int j = 0; j < 5; j++) step(7'h7F, 4'b0010, 1'b0, "unrec");
        chk("unrec_err1", 32'(err[1]), 1);
        chk("unrec_val1", 32'(valid[1]), 0);
        chk("unrec_dig1", 32'(dig[7:4]), 2);
        for (int j = 0; j < 5; j++) step(tbl[1], 4'b0010, 1'b0, "unrec_fix");
        chk("fix_err1", 32'(err[1]), 0);
        chk("fix_val1", 32'(valid[1]), 1);
        chk("fix_dig1", 32'(dig[7:4]), 1);

        // Invalid select patterns
        upd_seen = 0;
        for (int j = 0; j < 10; j++) step(tbl[5], 4'b0000, 1'b0, "badsel0");
        for (int j = 0; j < 10; j++) step(tbl[6], 4'b0110, 1'b0, "badsel6");
        chk("badsel_updcnt", 32'(upd_seen), 0);

        // Clear coinciding with the accept edge for digit 3
        for (int j = 0; j < 4; j++) step(tbl[9], 4'b1000, 1'b0, "clrcol_pre");
        step(tbl[9], 4'b1000, 1'b1, "clrcol");
        chk("clrcol_valid", 32'(valid), 32'h8);
        chk("clrcol_dig", 32'(dig), 32'h931F);
        chk("clrcol_upd", 32'(upd), 1);

        // Asynchronous reset in the middle of a count
        step(tbl[7], 4'b0001, 1'b0, "rst_pre");
        step(tbl[7], 4'b0001, 1'b0, "rst_pre");
        rst = 1'b1;
        #1;
        chk("async_dig", 32'(dig), 0);
        chk("async_valid", 32'(valid), 0);
        chk("async_err", 32'(err), 0);
        chk("async_upd", 32'(upd), 0);
        #2;
        rst = 1'b0;
        model_reset();
        for (int j = 0; j < SC; j++) step(tbl[7], 4'b0001, 1'b0, "rst_post");
        chk("rst_post_early", 32'(valid[0]), 0);
        step(tbl[7], 4'b0001, 1'b0, "rst_post");
        chk("rst_post_dig0", 32'(dig[3:0]), 7);
        chk("rst_post_upd", 32'(upd), 1);

        // Randomized bursts against the reference model
        for (int b = 0; b < 60; b++) begin
            logic [6:0]    rp;
            logic [ND-1:0] rs;
            int            hold;
            rp = ($urandom_range(0, 9) < 8) ? tbl[$urandom_range(0, 15)] : 7'($urandom);
            rs = ($urandom_range(0, 9) < 7) ? ND'(1 << $urandom_range(0, ND - 1)) : ND'($urandom);
            hold = $urandom_range(1, 7);
            for (int j = 0; j < hold; j++)
                step(rp, rs, ($urandom_range(0, 9) == 0), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
